// File: rtl/au_order_sched.sv
// Arbitrates the AU local program sequencer between the operation unit and the io unit,
// keeping one order in flight, with per-order watchdog and clear-A abort.
module au_order_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 127,
    parameter int unsigned CNT_W          = 7,
    parameter int unsigned RR_EN          = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_a_from_pu,
    input  logic       op_req_from_op,
    input  logic [2:0] op_code_from_op,
    input  logic       io_req_from_io,
    input  logic       au_answer_from_au,
    input  logic       io_answer_from_au,
    output logic       order_add_to_au,
    output logic       order_sub_to_au,
    output logic       order_mul_to_au,
    output logic       order_div_to_au,
    output logic       order_and_to_au,
    output logic       order_io_to_au,
    output logic       op_grant_to_op,
    output logic       io_grant_to_io,
    output logic       op_done_to_op,
    output logic       io_done_to_io,
    output logic       op_illegal_to_op,
    output logic       busy_to_pu,
    output logic       timeout_err_to_pnl
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_ISSUE = 5'b00010,
        S_WAIT  = 5'b00100,
        S_DONE  = 5'b01000,
        S_ERR   = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [2:0]       CODE_IO   = 3'd7;

    state_t           state_q, state_d;
    logic             owner_io_q, owner_io_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rr_io_q, rr_io_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             pick_io;
    logic             owner_answer;

    assign cnt_inc      = cnt_q + 1'b1;
    // On a tie io wins only when round-robin points at it, or when fixed priority is selected.
    assign pick_io      = io_req_from_io && (!op_req_from_op || (RR_EN == 0) || rr_io_q);
    assign owner_answer = owner_io_q ? io_answer_from_au : au_answer_from_au;

    always_comb begin
        state_d    = state_q;
        owner_io_d = owner_io_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rr_io_d    = rr_io_q;
        if (clear_a_from_pu) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_req_from_op || io_req_from_io) begin
                        state_d    = S_ISSUE;
                        owner_io_d = pick_io;
                        code_d     = pick_io ? CODE_IO : op_code_from_op;
                        if (RR_EN != 0) rr_io_d = !pick_io;
                    end
                end
                S_ISSUE: begin
                    cnt_d   = '0;
                    state_d = (!owner_io_q && (code_q > 3'd4)) ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (owner_answer) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == TIMEOUT_C) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            owner_io_q <= 1'b0;
            code_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rr_io_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_io_q <= owner_io_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rr_io_q    <= rr_io_d;
        end
    end

    logic issue_op, issue_io;
    assign issue_op = (state_q == S_ISSUE) && !owner_io_q;
    assign issue_io = (state_q == S_ISSUE) && owner_io_q;

    assign order_add_to_au    = issue_op && (code_q == 3'd0);
    assign order_sub_to_au    = issue_op && (code_q == 3'd1);
    assign order_mul_to_au    = issue_op && (code_q == 3'd2);
    assign order_div_to_au    = issue_op && (code_q == 3'd3);
    assign order_and_to_au    = issue_op && (code_q == 3'd4);
    assign order_io_to_au     = issue_io;
    assign op_grant_to_op     = issue_op;
    assign io_grant_to_io     = issue_io;
    assign op_illegal_to_op   = issue_op && (code_q > 3'd4);
    assign op_done_to_op      = (state_q == S_DONE) && !owner_io_q;
    assign io_done_to_io      = (state_q == S_DONE) && owner_io_q;
    assign busy_to_pu         = (state_q != S_IDLE);
    assign timeout_err_to_pnl = err_q;

endmodule

// File: tb/tb_au_order_sched.sv
// Directed bench for au_order_sched: expected pulse sets go into a scoreboard queue
// and are popped whenever the DUT shows any pulse output.
module tb_au_order_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_a_from_pu = 1'b0;
    logic       op_req_from_op = 1'b0;
    logic [2:0] op_code_from_op = 3'd0;
    logic       io_req_from_io = 1'b0;
    logic       au_answer_from_au = 1'b0;
    logic       io_answer_from_au = 1'b0;
    logic       order_add_to_au, order_sub_to_au, order_mul_to_au, order_div_to_au;
    logic       order_and_to_au, order_io_to_au;
    logic       op_grant_to_op, io_grant_to_io, op_done_to_op, io_done_to_io;
    logic       op_illegal_to_op, busy_to_pu, timeout_err_to_pnl;

    localparam logic [10:0] P_ADD = 11'h400, P_SUB = 11'h200, P_MUL = 11'h100, P_DIV = 11'h080;
    localparam logic [10:0] P_AND = 11'h040, P_IO  = 11'h020, P_OPG = 11'h010, P_IOG = 11'h008;
    localparam logic [10:0] P_OPD = 11'h004, P_IOD = 11'h002, P_ILL = 11'h001;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [10:0] sb[$];
    logic [10:0] pulses;

    au_order_sched #(.TIMEOUT_CYCLES(127), .CNT_W(7), .RR_EN(1)) dut (
        .clk(clk), .reset(reset), .clear_a_from_pu(clear_a_from_pu),
        .op_req_from_op(op_req_from_op), .op_code_from_op(op_code_from_op),
        .io_req_from_io(io_req_from_io), .au_answer_from_au(au_answer_from_au),
        .io_answer_from_au(io_answer_from_au),
        .order_add_to_au(order_add_to_au), .order_sub_to_au(order_sub_to_au),
        .order_mul_to_au(order_mul_to_au), .order_div_to_au(order_div_to_au),
        .order_and_to_au(order_and_to_au), .order_io_to_au(order_io_to_au),
        .op_grant_to_op(op_grant_to_op), .io_grant_to_io(io_grant_to_io),
        .op_done_to_op(op_done_to_op), .io_done_to_io(io_done_to_io),
        .op_illegal_to_op(op_illegal_to_op), .busy_to_pu(busy_to_pu),
        .timeout_err_to_pnl(timeout_err_to_pnl)
    );

    always #5 clk = ~clk;

    assign pulses = {order_add_to_au, order_sub_to_au, order_mul_to_au, order_div_to_au,
                     order_and_to_au, order_io_to_au, op_grant_to_op, io_grant_to_io,
                     op_done_to_op, io_done_to_io, op_illegal_to_op};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then sample 1 time unit after the edge; any pulse must match the queue head.
    task automatic tick();
        logic [10:0] exp;
        @(posedge clk);
        #1;
        if (pulses !== 11'h000) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {21'd0, pulses}, 32'd0);
            end else begin
                exp = sb.pop_front();
                check("sb_pulse", {21'd0, pulses}, {21'd0, exp});
            end
        end
    endtask

    initial begin
        // reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", busy_to_pu, 0);
        check("rst_err", timeout_err_to_pnl, 0);
        check("rst_pulses", pulses, 0);

        // mul order, answer after 60 cycles
        op_req_from_op = 1'b1; op_code_from_op = 3'd2;
        sb.push_back(P_MUL | P_OPG);
        tick();
        check("mul_grant_now", pulses, P_MUL | P_OPG);
        check("mul_busy", busy_to_pu, 1);
        op_req_from_op = 1'b0;
        repeat (60) tick();
        check("mul_wait_busy", busy_to_pu, 1);
        au_answer_from_au = 1'b1;
        sb.push_back(P_OPD);
        tick();
        au_answer_from_au = 1'b0;
        check("mul_done_now", pulses, P_OPD);
        tick();
        check("mul_idle", busy_to_pu, 0);

        // round-robin tie from reset state: op first, then io, next tie op
        reset = 1'b1; tick(); reset = 1'b0;
        op_req_from_op = 1'b1; op_code_from_op = 3'd0; io_req_from_io = 1'b1;
        sb.push_back(P_ADD | P_OPG);
        tick();
        check("tie1_op", pulses, P_ADD | P_OPG);
        op_req_from_op = 1'b0;
        tick();
        au_answer_from_au = 1'b1;
        sb.push_back(P_OPD);
        tick();
        au_answer_from_au = 1'b0;
        sb.push_back(P_IO | P_IOG);
        tick(); tick();
        check("tie1_io_after", pulses, P_IO | P_IOG);
        io_req_from_io = 1'b0;
        tick();
        io_answer_from_au = 1'b1;
        sb.push_back(P_IOD);
        tick();
        io_answer_from_au = 1'b0;
        tick();
        op_req_from_op = 1'b1; op_code_from_op = 3'd4; io_req_from_io = 1'b1;
        sb.push_back(P_AND | P_OPG);
        tick();
        check("tie2_op", pulses, P_AND | P_OPG);
        op_req_from_op = 1'b0; io_req_from_io = 1'b0;
        clear_a_from_pu = 1'b1;
        tick();
        clear_a_from_pu = 1'b0;
        check("tie2_cleared", busy_to_pu, 0);
        tick(); tick();

        // illegal op code
        op_req_from_op = 1'b1; op_code_from_op = 3'd6;
        sb.push_back(P_OPG | P_ILL);
        tick();
        check("ill_pulse", pulses, P_OPG | P_ILL);
        check("ill_busy", busy_to_pu, 1);
        op_req_from_op = 1'b0;
        tick();
        check("ill_idle", busy_to_pu, 0);
        tick(); tick();

        // io watchdog timeout, then clear
        io_req_from_io = 1'b1;
        sb.push_back(P_IO | P_IOG);
        tick();
        io_req_from_io = 1'b0;
        repeat (127) tick();
        check("to_not_yet", timeout_err_to_pnl, 0);
        tick();
        check("to_err", timeout_err_to_pnl, 1);
        check("to_busy", busy_to_pu, 1);
        io_answer_from_au = 1'b1;
        tick();
        io_answer_from_au = 1'b0;
        repeat (4) tick();
        check("to_sticky", timeout_err_to_pnl, 1);
        clear_a_from_pu = 1'b1;
        tick();
        clear_a_from_pu = 1'b0;
        check("to_clr_err", timeout_err_to_pnl, 0);
        check("to_clr_idle", busy_to_pu, 0);

        // clear beats same-cycle answer
        op_req_from_op = 1'b1; op_code_from_op = 3'd0;
        sb.push_back(P_ADD | P_OPG);
        tick();
        op_req_from_op = 1'b0;
        tick(); tick();
        clear_a_from_pu = 1'b1; au_answer_from_au = 1'b1;
        tick();
        clear_a_from_pu = 1'b0; au_answer_from_au = 1'b0;
        check("clr_ans_idle", busy_to_pu, 0);
        tick(); tick();

        // io owner ignores au_answer
        io_req_from_io = 1'b1;
        sb.push_back(P_IO | P_IOG);
        tick();
        io_req_from_io = 1'b0;
        tick();
        au_answer_from_au = 1'b1;
        tick();
        au_answer_from_au = 1'b0;
        check("io_ign_busy", busy_to_pu, 1);
        tick();
        check("io_ign_busy2", busy_to_pu, 1);
        io_answer_from_au = 1'b1;
        sb.push_back(P_IOD);
        tick();
        io_answer_from_au = 1'b0;
        check("io_done_now", pulses, P_IOD);
        tick();
        check("io_idle", busy_to_pu, 0);
        tick();

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
